// File: rtl/fft_output_reorder_buffer.sv
// Reorders paired FFT results (X[p], X[p+32]) into natural-order bins 0..63 through
// a ping-pong pair of 64-entry banks, with a valid/ready stream on the output side.
module fft_output_reorder_buffer #(
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            i_pair_valid,
  input  logic [4:0]      i_pair_idx,
  input  logic [2*DW-1:0] i_pair_d0,
  input  logic [2*DW-1:0] i_pair_d1,
  output logic [2*DW-1:0] o_dout,
  output logic [5:0]      o_dout_idx,
  output logic            o_dout_valid,
  input  logic            i_dout_ready,
  output logic            o_dout_last,
  output logic            o_frame_done,
  output logic            o_overflow
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FILLING,
    ST_FULL,
    ST_DRAINING
  } bank_state_e;

  bank_state_e     r_bank_state     [2];
  bank_state_e     w_bank_state_nxt [2];
  logic            r_wbank, w_wbank_nxt;
  logic [5:0]      r_wcnt, w_wcnt_nxt;
  logic            r_rbank, w_rbank_nxt;
  logic [5:0]      r_rptr, w_rptr_nxt;

  logic [2*DW-1:0] r_mem [2][64];

  logic [2*DW-1:0] r_dout;
  logic [5:0]      r_dout_idx;
  logic            r_dout_valid;
  logic            r_dout_last;
  logic            r_frame_done;
  logic            r_overflow;

  logic            w_wr_en;
  logic            w_drop;
  logic            w_out_free;
  logic            w_handshake;
  logic            w_last_hs;
  logic            w_load;
  logic            w_ld_bank;
  logic [5:0]      w_ld_addr;

  // A bank only accepts writes while it holds no complete frame, so the
  // reader can never see a partially written bank.
  assign w_wr_en     = i_pair_valid &&
                       (r_bank_state[r_wbank] == ST_EMPTY ||
                        r_bank_state[r_wbank] == ST_FILLING);
  assign w_drop      = i_pair_valid && !w_wr_en;
  assign w_out_free  = !r_dout_valid || i_dout_ready;
  assign w_handshake = r_dout_valid && i_dout_ready;
  assign w_last_hs   = w_handshake && r_dout_last;

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    w_bank_state_nxt = r_bank_state;
    w_wbank_nxt      = r_wbank;
    w_wcnt_nxt       = r_wcnt;
    w_rbank_nxt      = r_rbank;
    w_rptr_nxt       = r_rptr;
    w_load           = 1'b0;
    w_ld_bank        = r_rbank;
    w_ld_addr        = r_rptr;

    // Write side only touches EMPTY/FILLING banks, read side only FULL/DRAINING,
    // so both may update the state array in the same cycle without conflict.
    if (w_wr_en) begin
      if (r_wcnt == 6'd31) begin
        w_bank_state_nxt[r_wbank] = ST_FULL;
        w_wcnt_nxt                = 6'd0;
        w_wbank_nxt               = ~r_wbank;
      end else begin
        w_bank_state_nxt[r_wbank] = ST_FILLING;
        w_wcnt_nxt                = r_wcnt + 6'd1;
      end
    end

    case (r_bank_state[r_rbank])
      ST_FULL: begin
        if (w_out_free) begin
          w_bank_state_nxt[r_rbank] = ST_DRAINING;
          w_load                    = 1'b1;
          w_ld_addr                 = 6'd0;
          w_rptr_nxt                = 6'd1;
        end
      end
      ST_DRAINING: begin
        // rptr wraps to 0 once bin 63 is loaded; then wait for its handshake.
        if (r_rptr != 6'd0) begin
          if (w_out_free) begin
            w_load     = 1'b1;
            w_rptr_nxt = r_rptr + 6'd1;
          end
        end else if (w_last_hs) begin
          w_bank_state_nxt[r_rbank] = ST_EMPTY;
          w_rbank_nxt               = ~r_rbank;
          w_rptr_nxt                = 6'd0;
          if (r_bank_state[~r_rbank] == ST_FULL) begin
            w_bank_state_nxt[~r_rbank] = ST_DRAINING;
            w_load                     = 1'b1;
            w_ld_bank                  = ~r_rbank;
            w_ld_addr                  = 6'd0;
            w_rptr_nxt                 = 6'd1;
          end
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_bank_state <= '{default: ST_EMPTY};
      r_wbank      <= 1'b0;
      r_wcnt       <= 6'd0;
      r_rbank      <= 1'b0;
      r_rptr       <= 6'd0;
      r_dout       <= '0;
      r_dout_idx   <= 6'd0;
      r_dout_valid <= 1'b0;
      r_dout_last  <= 1'b0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_bank_state <= w_bank_state_nxt;
      r_wbank      <= w_wbank_nxt;
      r_wcnt       <= w_wcnt_nxt;
      r_rbank      <= w_rbank_nxt;
      r_rptr       <= w_rptr_nxt;
      if (w_load) begin
        r_dout       <= r_mem[w_ld_bank][w_ld_addr];
        r_dout_idx   <= w_ld_addr;
        r_dout_valid <= 1'b1;
        r_dout_last  <= (w_ld_addr == 6'd63);
      end else if (w_handshake) begin
        r_dout_valid <= 1'b0;
        r_dout_last  <= 1'b0;
      end
      r_frame_done <= w_last_hs;
      r_overflow   <= r_overflow | w_drop;
    end
  end

  // NOTE: bank storage has no reset; bin data is only read after a full frame is written.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wbank][{1'b0, i_pair_idx}] <= i_pair_d0;
      r_mem[r_wbank][{1'b1, i_pair_idx}] <= i_pair_d1;
    end
  end

  assign o_dout       = r_dout;
  assign o_dout_idx   = r_dout_idx;
  assign o_dout_valid = r_dout_valid;
  assign o_dout_last  = r_dout_last;
  assign o_frame_done = r_frame_done;
  assign o_overflow   = r_overflow;

endmodule
